// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage MIPS pipeline: load-use stalls, EX/MEM branch flushes and data-memory waits.
// Optional performance counters are enabled by defining STALL_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_mem_acc,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
`ifdef STALL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] memwait_cycles,
`endif
    output logic             mem_error
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_C = WCW'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_params
        $error("pipeline_hazard_ctrl: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t         r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_error;

    logic w_load_use;
    logic w_br_taken;
    logic w_mem_stall;
    logic w_active;
    logic w_mem_hold;
    logic w_issue_br;
    logic w_issue_lu;

    assign w_load_use  = idex_mem_read && (idex_rt != {REG_W{1'b0}}) &&
                         ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign w_br_taken  = exmem_branch & exmem_zero;
    assign w_mem_stall = exmem_mem_acc & ~dmem_ready;
    assign w_active    = (r_state == RUN) || (r_state == MEM_WAIT);
    // In MEM_WAIT the hold is released purely by dmem_ready; the release cycle then behaves like RUN.
    assign w_mem_hold  = ((r_state == RUN) && w_mem_stall) ||
                         ((r_state == MEM_WAIT) && !dmem_ready);
    assign w_issue_br  = w_active & ~w_mem_hold & w_br_taken;
    assign w_issue_lu  = w_active & ~w_mem_hold & ~w_br_taken & w_load_use;

    // Mealy strobe decode, forced quiet while reset is asserted.
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
        end else begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (w_mem_hold) begin
                        memwb_flush = 1'b1;
                    end else if (w_issue_br) begin
                        pc_write    = 1'b1;
                        pc_src      = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (w_issue_lu) begin
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        idex_flush  = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                    end
                end
                ERROR:   pc_write = 1'b0;
                default: pc_write = 1'b0;
            endcase
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= {WCW{1'b0}};
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WCW'(1);
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= {WCW{1'b0}};
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= {WCW{1'b0}};
                    end else if (r_wait_cnt == TIMEOUT_C) begin
                        r_state     <= ERROR;
                        r_mem_error <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                ERROR: begin
                    if (err_clr) begin
                        r_state     <= RUN;
                        r_wait_cnt  <= {WCW{1'b0}};
                        r_mem_error <= 1'b0;
                    end else begin
                        r_state <= ERROR;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_wait_cnt  <= {WCW{1'b0}};
                    r_mem_error <= 1'b0;
                end
            endcase
        end
    end

    assign mem_error = r_mem_error;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_memwait_cycles;

    // Saturating event counters; the memory-wait count covers every cycle the mem hold is applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles   <= {CNT_W{1'b0}};
            r_flush_count    <= {CNT_W{1'b0}};
            r_memwait_cycles <= {CNT_W{1'b0}};
        end else begin
            if (w_issue_lu && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_issue_br && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
            if (w_mem_hold && (r_memwait_cycles != {CNT_W{1'b1}})) begin
                r_memwait_cycles <= r_memwait_cycles + CNT_W'(1);
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign flush_count    = r_flush_count;
    assign memwait_cycles = r_memwait_cycles;
`endif

endmodule
